// File: rtl/div_share_if.sv
// -----------------------------------------------------------------------------
// div_share_if
//   Bundles every signal between the shared-divider scheduler and its
//   surroundings: the two issue-slot request channels, the completion
//   response, the divider start/ready/annul channel, the pipeline flush,
//   and status/debug outputs.
//
//   modport slave  : view taken by div_share_ctrl (the scheduler itself)
//   modport master : view taken by the environment (ALU slots + divider)
//
//   Signals:
//     flush                      pipeline flush
//     req{0,1}_valid/_signed/_a/_b  divide request per issue slot
//     resp{0,1}_done, resp_result   completion pulse per slot, shared result
//     div_start/_signed/_a/_b    operation to the divider
//     div_annul                  one-cycle abort to the divider
//     div_ready, div_result      divider completion
//     busy                       scheduler owns the divider or is completing
//     dbg_state                  scheduler FSM state (IDLE=0, BUSY=1, DONE=2)
// -----------------------------------------------------------------------------
interface div_share_if #(
    parameter int WIDTH = 32
);
    logic                   flush;
    logic                   req0_valid;
    logic                   req0_signed;
    logic [WIDTH-1:0]       req0_a;
    logic [WIDTH-1:0]       req0_b;
    logic                   req1_valid;
    logic                   req1_signed;
    logic [WIDTH-1:0]       req1_a;
    logic [WIDTH-1:0]       req1_b;
    logic                   resp0_done;
    logic                   resp1_done;
    logic [2*WIDTH-1:0]     resp_result;
    logic                   div_start;
    logic                   div_signed;
    logic [WIDTH-1:0]       div_a;
    logic [WIDTH-1:0]       div_b;
    logic                   div_annul;
    logic                   div_ready;
    logic [2*WIDTH-1:0]     div_result;
    logic                   busy;
    logic [1:0]             dbg_state;

    modport slave (
        input  flush,
        input  req0_valid, req0_signed, req0_a, req0_b,
        input  req1_valid, req1_signed, req1_a, req1_b,
        output resp0_done, resp1_done, resp_result,
        output div_start, div_signed, div_a, div_b, div_annul,
        input  div_ready, div_result,
        output busy, dbg_state
    );

    modport master (
        output flush,
        output req0_valid, req0_signed, req0_a, req0_b,
        output req1_valid, req1_signed, req1_a, req1_b,
        input  resp0_done, resp1_done, resp_result,
        input  div_start, div_signed, div_a, div_b, div_annul,
        output div_ready, div_result,
        input  busy, dbg_state
    );
endinterface

// File: rtl/div_share_ctrl.sv
// -----------------------------------------------------------------------------
// div_share_ctrl
//   Shares one iterative divider between the master (slot 0) and slave
//   (slot 1) ALUs of the dual-issue execute stage. Arbitrates round-robin
//   between the two divide requests, sequences the divider start/ready/annul
//   handshake and keeps a one-entry result cache so a divide replayed after
//   a pipeline stall completes without re-running the divider.
//
//   Ports:
//     clk   clock
//     rst   synchronous reset, active-low
//     bus   div_share_if.slave (requests, responses, divider channel,
//           flush, busy, dbg_state)
//
//   Handshake semantics:
//     A slot raises reqN_valid with stable operands and holds it until it
//     sees respN_done for one cycle; dropping reqN_valid early withdraws the
//     request. The divider sees div_start held high for the whole operation
//     with stable operands and answers with a one-cycle div_ready; a
//     one-cycle div_annul (with div_start low) tells it to abandon the
//     operation instead.
// -----------------------------------------------------------------------------
module div_share_ctrl #(
    parameter int WIDTH    = 32,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    div_share_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   ptr_q;      // preferred side when both request
    logic                   gnt_q;      // side currently being served

    // Working registers: operands held for the divider during BUSY.
    logic [WIDTH-1:0]       wa_q;
    logic [WIDTH-1:0]       wb_q;
    logic                   ws_q;

    logic                   start_q;
    logic                   done0_q;
    logic                   done1_q;
    logic [2*WIDTH-1:0]     result_q;

    // One-entry last-result cache.
    logic                   cache_valid_q;
    logic [WIDTH-1:0]       cache_a_q;
    logic [WIDTH-1:0]       cache_b_q;
    logic                   cache_s_q;
    logic [2*WIDTH-1:0]     cache_r_q;

    logic                   gnt_valid;
    logic                   abort;
    logic                   any_req;
    logic                   pick;
    logic [WIDTH-1:0]       sel_a;
    logic [WIDTH-1:0]       sel_b;
    logic                   sel_s;
    logic                   hit;

    always_comb begin
        gnt_valid = gnt_q ? bus.req1_valid : bus.req0_valid;
        // Reset is excluded so a reset mid-operation never pulses annul;
        // the divider is cleared by the same reset.
        abort     = (state_q == ST_BUSY) && rst && (bus.flush || !gnt_valid);
        any_req   = (bus.req0_valid || bus.req1_valid) && !bus.flush;
        // With a single requester it wins outright; with two, the pointer decides.
        pick      = (bus.req0_valid && bus.req1_valid) ? ptr_q : bus.req1_valid;
        sel_a     = pick ? bus.req1_a      : bus.req0_a;
        sel_b     = pick ? bus.req1_b      : bus.req0_b;
        sel_s     = pick ? bus.req1_signed : bus.req0_signed;
        hit       = CACHE_EN && cache_valid_q &&
                    (sel_a == cache_a_q) && (sel_b == cache_b_q) &&
                    (sel_s == cache_s_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 1'b0;
            gnt_q         <= 1'b0;
            wa_q          <= '0;
            wb_q          <= '0;
            ws_q          <= 1'b0;
            start_q       <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            result_q      <= '0;
            cache_valid_q <= 1'b0;
            cache_a_q     <= '0;
            cache_b_q     <= '0;
            cache_s_q     <= 1'b0;
            cache_r_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    if (any_req) begin
                        gnt_q <= pick;
                        if (hit) begin
                            // Replay of the cached op: divider is not touched.
                            result_q <= cache_r_q;
                            done0_q  <= !pick;
                            done1_q  <= pick;
                            state_q  <= ST_DONE;
                        end else begin
                            wa_q    <= sel_a;
                            wb_q    <= sel_b;
                            ws_q    <= sel_s;
                            start_q <= 1'b1;
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (abort) begin
                        // Abort beats a coincident div_ready: nothing is kept.
                        start_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (bus.div_ready) begin
                        result_q      <= bus.div_result;
                        cache_valid_q <= 1'b1;
                        cache_a_q     <= wa_q;
                        cache_b_q     <= wb_q;
                        cache_s_q     <= ws_q;
                        cache_r_q     <= bus.div_result;
                        start_q       <= 1'b0;
                        done0_q       <= !gnt_q;
                        done1_q       <= gnt_q;
                        state_q       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    ptr_q   <= !gnt_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    start_q <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Flush during DONE squashes the completion pulse; the cache write from
    // the preceding BUSY cycle stays.
    assign bus.resp0_done  = done0_q && !bus.flush;
    assign bus.resp1_done  = done1_q && !bus.flush;
    assign bus.resp_result = result_q;

    // div_start drops in the abort cycle itself, alongside div_annul.
    assign bus.div_start   = start_q && !abort;
    assign bus.div_annul   = abort;
    assign bus.div_signed  = ws_q;
    assign bus.div_a       = wa_q;
    assign bus.div_b       = wb_q;

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.dbg_state   = state_q;

endmodule
